// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : loader_pkg
// Description : Shared types and defaults for the UART boot loader: FSM state
//               encoding, default frame start byte, frame field byte counts
//               and default load window (base address / depth).
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

   // Loader FSM states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [7:0]  c_magic_default       = 8'hA5;
   localparam int          c_len_bytes           = 2;
   localparam int          c_csum_bytes          = 1;
   localparam int          c_len_width           = 8 * c_len_bytes;
   localparam logic [31:0] c_base_addr_default   = 32'h0000_0000;
   localparam int          c_depth_words_default = 64;

endpackage
`default_nettype wire

// File: rtl/ld_timeout.sv
`default_nettype none
// ============================================================================
// Module      : ld_timeout
// Description : Loadable down-counter used as the inter-byte watchdog.
//               clr reloads LOAD_VAL, en decrements, expired flags zero.
// Ports       : clk     - system clock
//               reset   - asynchronous active-low reset
//               clr     - reload counter to LOAD_VAL
//               en      - count down one step
//               expired - counter has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module ld_timeout #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] LOAD_VAL = '1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= LOAD_VAL;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_loader
// Description : Holds the CPU while a framed program image is pulled from the
//               UART RX FIFO and written word by word into data RAM. Frame:
//               MAGIC, LEN_LO, LEN_HI, N*4 payload bytes, CSUM (XOR of
//               payload). On a good checksum the RAM/UART ports are handed
//               back to the CPU; reload re-arms the loader at any time.
// Ports       : clk, reset (async active-low), reload
//               rx_empty, r_data             - UART RX FIFO head
//               cpu_rd_uart, cpu_we,
//               cpu_addr, cpu_wdata          - CPU side requests
//               uart_rd, ram_we,
//               ram_addr, ram_wdata          - muxed RAM/UART controls
//               cpu_hold, load_done, load_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_boot_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = c_base_addr_default,
   parameter int          DEPTH_WORDS = c_depth_words_default,
   parameter int          TIMEOUT     = 50000,
   parameter logic [7:0]  MAGIC       = c_magic_default
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reload,
   input  logic        rx_empty,
   input  logic [7:0]  r_data,
   input  logic        cpu_rd_uart,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        uart_rd,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   state_t                 r_state, w_state_nxt;
   logic                   r_pend, r_hold, r_done, r_err, r_we;
   logic [31:0]            r_waddr, r_wdata;
   logic [c_len_width-1:0] r_len, r_idx;
   logic [1:0]             r_bcnt;
   logic [23:0]            r_pack;
   logic [7:0]             r_csum;
   logic                   w_accept, w_in_frame, w_tmo_clr, w_tmo_expired;
   logic                   w_err_evt, w_done_evt;
   logic [c_len_width-1:0] w_len_rx;

   // Reset gating keeps the pop strobe low while reset is held even with
   // data waiting in the FIFO.
   assign w_accept   = reset && (r_state != ST_DONE) && !rx_empty && !r_pend && !reload;
   assign w_in_frame = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM);
   assign w_len_rx   = {r_data, r_len[7:0]};
   assign w_tmo_clr  = reload || w_accept || !w_in_frame;

   ld_timeout #(
      .WIDTH    (32),
      .LOAD_VAL (32'(TIMEOUT - 1))
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (w_tmo_clr),
      .en      (w_in_frame),
      .expired (w_tmo_expired)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_err_evt   = 1'b0;
      w_done_evt  = 1'b0;
      if (reload) begin
         w_state_nxt = ST_IDLE;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE: if (r_data == MAGIC) w_state_nxt = ST_LEN0;
            ST_LEN0: w_state_nxt = ST_LEN1;
            ST_LEN1: begin
               if (32'(w_len_rx) > 32'(DEPTH_WORDS)) w_err_evt   = 1'b1;
               else if (w_len_rx == '0)              w_state_nxt = ST_CSUM;
               else                                  w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
               if ((r_bcnt == 2'd3) && ((32'(r_idx) + 32'd1) == 32'(r_len)))
                  w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
               if (r_data == r_csum) begin
                  w_state_nxt = ST_DONE;
                  w_done_evt  = 1'b1;
               end else begin
                  w_err_evt = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (w_in_frame && w_tmo_expired) begin
         w_err_evt = 1'b1;
      end
      if (w_err_evt) w_state_nxt = ST_IDLE;
   end

   // ---------------- datapath: packer, checksum, write port ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend  <= 1'b0;
         r_hold  <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_bcnt  <= '0;
         r_pack  <= '0;
         r_csum  <= '0;
      end else begin
         r_we   <= 1'b0;
         r_pend <= w_accept;
         if (reload) begin
            r_hold <= 1'b1;
            r_done <= 1'b0;
         end else begin
            if (w_err_evt) begin
               r_err <= 1'b1;
               r_idx <= '0;
            end
            if (w_done_evt) begin
               r_done <= 1'b1;
               r_hold <= 1'b0;
            end
            if (w_accept) begin
               case (r_state)
                  ST_IDLE: begin
                     if (r_data == MAGIC) begin
                        r_err  <= 1'b0;
                        r_csum <= '0;
                        r_idx  <= '0;
                        r_bcnt <= '0;
                     end
                  end
                  ST_LEN0: r_len[7:0] <= r_data;
                  ST_LEN1: begin
                     r_len[15:8] <= r_data;
                     r_bcnt      <= '0;
                  end
                  ST_DATA: begin
                     // Little-endian: first byte ends up in the low lane.
                     r_pack <= {r_data, r_pack[23:8]};
                     r_csum <= r_csum ^ r_data;
                     r_bcnt <= r_bcnt + 2'd1;
                     if (r_bcnt == 2'd3) begin
                        r_we    <= 1'b1;
                        r_waddr <= BASE_ADDR + (32'(r_idx) << 2);
                        r_wdata <= {r_data, r_pack};
                        r_idx   <= r_idx + c_len_width'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // ---------------- output / port mux ----------------
   always_comb begin
      cpu_hold  = r_hold;
      load_done = r_done;
      load_err  = r_err;
      if (r_hold) begin
         uart_rd   = w_accept;
         ram_we    = r_we;
         ram_addr  = r_waddr;
         ram_wdata = r_wdata;
      end else begin
         uart_rd   = cpu_rd_uart;
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_boot_loader
// Description : Self-checking bench for uart_boot_loader. A byte queue stands
//               in for the UART RX FIFO; frames are scored against a
//               frame-level reference model plus fixed table expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          DEPTH = 64;
   localparam int          TMO   = 40;
   localparam logic [7:0]  MAG   = 8'hA5;

   logic        clk = 1'b0;
   logic        reset, reload, rx_empty, cpu_rd_uart, cpu_we;
   logic [7:0]  r_data;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        uart_rd, ram_we, cpu_hold, load_done, load_err;
   logic [31:0] ram_addr, ram_wdata;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .TIMEOUT     (TMO),
      .MAGIC       (MAG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reload      (reload),
      .rx_empty    (rx_empty),
      .r_data      (r_data),
      .cpu_rd_uart (cpu_rd_uart),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .uart_rd     (uart_rd),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .cpu_hold    (cpu_hold),
      .load_done   (load_done),
      .load_err    (load_err)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      int unsigned c;
   } wr_t;

   typedef struct packed {
      logic [127:0] b;
      int unsigned  len;
      logic         e_done;
      logic         e_err;
      int unsigned  e_nwr;
   } vec_t;

   logic [7:0]  src[$];
   logic [7:0]  fifo[$];
   int unsigned pop_cyc[$];
   wr_t         wlog[$];
   wr_t         mexp[$];
   bit          m_done, m_err;
   int unsigned cyc;
   int          n_pass = 0;
   int          n_total = 0;
   vec_t        vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic upd_fifo();
      rx_empty = (fifo.size() == 0);
      r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
   endtask

   // One clock: sample just before the edge, pop/feed just after it.
   task automatic step();
      bit  pop;
      wr_t t;
      #1;
      pop = (uart_rd === 1'b1) && (fifo.size() > 0);
      if (pop) pop_cyc.push_back(cyc);
      if (ram_we === 1'b1) begin
         t.addr = ram_addr;
         t.data = ram_wdata;
         t.c    = cyc;
         wlog.push_back(t);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pop) void'(fifo.pop_front());
      if (src.size() > 0 && $urandom_range(0, 1) == 1) fifo.push_back(src.pop_front());
      upd_fifo();
      #1;
   endtask

   // Frame-level reference: expected writes (with stream index of the byte
   // that completes each word) and final outcome.
   function automatic void model(input logic [7:0] s[$]);
      int         p, n;
      logic [7:0] x;
      wr_t        t;
      mexp.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      p = 0;
      while (p < s.size() && s[p] != MAG) p++;
      if (p + 2 >= s.size()) return;
      n = int'(s[p+1]) + 256 * int'(s[p+2]);
      p = p + 3;
      if (n > DEPTH) begin
         m_err = 1'b1;
         return;
      end
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
         t.addr = BASE + 32'(4 * k);
         t.data = {s[p+3], s[p+2], s[p+1], s[p]};
         t.c    = 32'(p + 3);
         mexp.push_back(t);
         x = x ^ s[p] ^ s[p+1] ^ s[p+2] ^ s[p+3];
         p = p + 4;
      end
      m_done = (s[p] == x);
      m_err  = !m_done;
   endfunction

   task automatic drain(input string tag);
      int guard = 0;
      while ((src.size() > 0 || fifo.size() > 0) && guard < 3000) begin
         step();
         guard++;
      end
      chk({tag, "_drain_in_time"}, 32'(guard < 3000), 32'd1);
   endtask

   task automatic run_frame(input logic [7:0] s[$], input string tag);
      reload = 1'b1;
      step();
      reload = 1'b0;
      chk({tag, "_reload_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_reload_done"}, 32'(load_done), 32'd0);
      wlog.delete();
      pop_cyc.delete();
      model(s);
      src = s;
      drain(tag);
      repeat (4) step();
      chk({tag, "_pops"}, pop_cyc.size(), s.size());
      chk({tag, "_nwr"}, wlog.size(), mexp.size());
      for (int i = 0; i < wlog.size() && i < mexp.size(); i++) begin
         chk({tag, "_waddr"}, wlog[i].addr, mexp[i].addr);
         chk({tag, "_wdata"}, wlog[i].data, mexp[i].data);
         if (mexp[i].c < pop_cyc.size())
            chk({tag, "_wlat"}, wlog[i].c, pop_cyc[mexp[i].c] + 1);
         else
            chk({tag, "_wlat_nopop"}, 32'd0, 32'd1);
      end
      chk({tag, "_done"}, 32'(load_done), 32'(m_done));
      chk({tag, "_err"}, 32'(load_err), 32'(m_err));
      chk({tag, "_hold"}, 32'(cpu_hold), 32'(!m_done));
   endtask

   task automatic rnd_frame(input int n, input bit bad, input int ng);
      logic [7:0] q[$];
      logic [7:0] x, b;
      x = 8'h00;
      for (int g = 0; g < ng; g++) begin
         b = 8'($urandom_range(0, 255));
         while (b == MAG) b = 8'($urandom_range(0, 255));
         q.push_back(b);
      end
      q.push_back(MAG);
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      if (n <= DEPTH) begin
         for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom_range(0, 255));
            x = x ^ b;
            q.push_back(b);
         end
         q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
      end
      run_frame(q, "rnd");
   endtask

   function automatic void vec_to_q(input vec_t v, output logic [7:0] q[$]);
      q.delete();
      for (int i = 0; i < int'(v.len); i++) q.push_back(v.b[127 - 8*i -: 8]);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      int         guard;

      vecs[0] = '{{96'hA5020011223344556677_8888, 32'h0}, 12, 1'b1, 1'b0, 2};
      vecs[1] = '{{96'hA5020011223344556677_8800, 32'h0}, 12, 1'b0, 1'b1, 2};
      vecs[2] = '{{96'hA5020011223344556677_8888, 32'h0}, 12, 1'b1, 1'b0, 2};
      vecs[3] = '{{24'hA54100, 104'h0}, 3, 1'b0, 1'b1, 0};
      vecs[4] = '{{24'hA50001, 104'h0}, 3, 1'b0, 1'b1, 0};
      vecs[5] = '{{32'hA5000000, 96'h0}, 4, 1'b1, 1'b0, 0};
      vecs[6] = '{{80'h1234A50100DEADBEEF22, 48'h0}, 10, 1'b1, 1'b0, 1};

      // ---- reset values, CPU requests present and FIFO non-empty ----
      cyc = 0;
      reset = 1'b0;
      reload = 1'b0;
      cpu_we = 1'b1;
      cpu_rd_uart = 1'b1;
      cpu_addr = 32'h10;
      cpu_wdata = 32'h1234_5678;
      fifo.push_back(8'h12);
      upd_fifo();
      #12;
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_uart_rd", 32'(uart_rd), 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      cpu_we = 1'b0;
      cpu_rd_uart = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      reset = 1'b1;
      repeat (4) step();
      chk("idle_garbage_popped", fifo.size(), 0);
      chk("idle_garbage_no_err", 32'(load_err), 32'd0);

      // ---- table-driven frames ----
      for (int v = 0; v < 7; v++) begin
         vec_to_q(vecs[v], q);
         run_frame(q, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_tbl_done", v), 32'(load_done), 32'(vecs[v].e_done));
         chk($sformatf("vec%0d_tbl_err", v), 32'(load_err), 32'(vecs[v].e_err));
         chk($sformatf("vec%0d_tbl_nwr", v), wlog.size(), vecs[v].e_nwr);
         if (v == 0 && wlog.size() == 2) begin
            chk("vec0_word0", wlog[0].data, 32'h4433_2211);
            chk("vec0_word1", wlog[1].data, 32'h8877_6655);
            chk("vec0_addr1", wlog[1].addr, 32'h4);
         end
      end

      // ---- stall mid-payload: timeout ----
      reload = 1'b1;
      step();
      reload = 1'b0;
      wlog.delete();
      src = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
      drain("tmo");
      repeat (TMO - 6) step();
      chk("tmo_not_yet", 32'(load_err), 32'd0);
      repeat (10) step();
      chk("tmo_err", 32'(load_err), 32'd1);
      chk("tmo_hold", 32'(cpu_hold), 32'd1);
      chk("tmo_no_writes", wlog.size(), 0);
      vec_to_q(vecs[6], q);
      run_frame(q, "tmo_recover");

      // ---- CPU passthrough after load_done, then reload blocks it ----
      cpu_we = 1'b1;
      cpu_rd_uart = 1'b1;
      cpu_addr = 32'h10;
      cpu_wdata = 32'hCAFE_F00D;
      #1;
      chk("cpu_we_pass", 32'(ram_we), 32'd1);
      chk("cpu_addr_pass", ram_addr, 32'h10);
      chk("cpu_wdata_pass", ram_wdata, 32'hCAFE_F00D);
      chk("cpu_rd_pass", 32'(uart_rd), 32'd1);
      reload = 1'b1;
      step();
      reload = 1'b0;
      chk("reload_hold_next", 32'(cpu_hold), 32'd1);
      chk("reload_blocks_we", 32'(ram_we), 32'd0);
      chk("reload_blocks_rd", 32'(uart_rd), 32'd0);
      chk("reload_loader_addr", ram_addr, 32'h0);
      cpu_we = 1'b0;
      cpu_rd_uart = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      repeat (2) step();

      // ---- reload coinciding with a byte accept ----
      wlog.delete();
      pop_cyc.delete();
      fifo.push_back(MAG);
      upd_fifo();
      reload = 1'b1;
      #1;
      chk("reload_accept_no_pop", 32'(uart_rd), 32'd0);
      step();
      reload = 1'b0;
      chk("reload_accept_kept", fifo.size(), 1);
      src = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      drain("reload_accept");
      repeat (4) step();
      chk("reload_accept_done", 32'(load_done), 32'd1);
      chk("reload_accept_nwr", wlog.size(), 1);

      // ---- async reset mid-DATA ----
      reload = 1'b1;
      step();
      reload = 1'b0;
      wlog.delete();
      src = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      guard = 0;
      while (wlog.size() == 0 && guard < 300) begin
         step();
         guard++;
      end
      chk("arst_first_write", 32'(guard < 300), 32'd1);
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_hold", 32'(cpu_hold), 32'd1);
      chk("arst_done", 32'(load_done), 32'd0);
      chk("arst_err", 32'(load_err), 32'd0);
      chk("arst_ram_we", 32'(ram_we), 32'd0);
      chk("arst_uart_rd", 32'(uart_rd), 32'd0);
      chk("arst_ram_addr", ram_addr, 32'd0);
      chk("arst_ram_wdata", ram_wdata, 32'd0);
      src.delete();
      fifo.delete();
      upd_fifo();
      #2;
      reset = 1'b1;
      step();
      vec_to_q(vecs[0], q);
      run_frame(q, "post_rst");

      // ---- largest accepted frame ----
      rnd_frame(DEPTH, 1'b0, 0);

      // ---- randomized frames ----
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 9) == 0)
            rnd_frame(DEPTH + 1 + int'($urandom_range(0, 300)), 1'b0, int'($urandom_range(0, 2)));
         else
            rnd_frame(int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
